instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-002 Parameter: DEPTH, default 16, meaning the number of program-buffer entries, fixed at 16.
REQ-003 Parameter: IW, default 16, meaning the instruction width in bits.
REQ-004 Port: clk, input, 1 bit, meaning the rising-edge clock.
REQ-005 Port: rst, input, 1 bit, meaning the asynchronous active-high reset.
REQ-006 Port: wr_en, input, 1 bit, meaning the program-buffer write strobe.
REQ-007 Port: wr_addr, input, 4 bits, meaning the program-buffer write index.
REQ-008 Port: wr_data, input, 16 bits, meaning the instruction word to store.
REQ-009 Port: prog_len, input, 4 bits, meaning the index of the last instruction to run, sampled at start.
REQ-010 Port: start, input, 1 bit, meaning the run request, honoured only in IDLE.
REQ-011 Port: pause, input, 1 bit, meaning a level-sensitive hold of issue.
REQ-012 Port: instruction, output, 16 bits, meaning the registered word presented to the ALU datapath.
REQ-013 Port: issue, output, 1 bit, meaning the registered execute-enable for the datapath (datapath executes instruction only when issue=1).
REQ-014 Port: pc, output, 4 bits, meaning the registered program index.
REQ-015 Port: busy, output, 1 bit, meaning high in RUN or PAUSED.
REQ-016 Port: done, output, 1 bit, meaning a one-cycle completion pulse.

Function
REQ-017 The program buffer SHALL hold 16 x 16-bit words; a write occurs on a clk edge with wr_en=1, state=IDLE, start=0.
REQ-018 wr_en in any state other than IDLE, or together with start in IDLE, SHALL be ignored (buffer unchanged).
REQ-019 The FSM SHALL have states IDLE, RUN, PAUSED, DONE; busy SHALL be decoded from state (RUN or PAUSED).
REQ-020 IDLE to RUN on an edge with start=1: last<=prog_len, pc<=0, instruction<=buf[0], issue<=1.
REQ-021 RUN, pause=0, pc!=last: pc<=pc+1, instruction<=buf[pc+1], issue<=1 (one instruction per cycle, no bubbles).
REQ-022 RUN, pc==last (pause ignored): issue<=0, done<=1, go to DONE; pc holds last; instruction holds the final word.
REQ-023 RUN, pause=1, pc!=last: issue<=0, pc<=pc+1 (current word counted as executed), go to PAUSED.
REQ-024 PAUSED, pause=1: hold all outputs, issue=0.
REQ-025 PAUSED, pause=0: instruction<=buf[pc], issue<=1, go to RUN.
REQ-026 DONE SHALL last exactly one cycle: done<=0, go to IDLE; done is high only during the DONE cycle.
REQ-027 start in RUN, PAUSED or DONE SHALL be ignored.
REQ-028 prog_len=0 SHALL issue exactly one instruction (buf[0]); prog_len=15 SHALL issue all 16, with no pc wrap.
REQ-029 The number of issue-high cycles per run SHALL equal prog_len+1 regardless of pause activity.
REQ-030 pc arithmetic SHALL be 4-bit unsigned; pc never exceeds last.

Reset
REQ-031 rst=1 SHALL immediately, independent of clk, force state=IDLE, pc=0, last=0, instruction=16'h0000, issue=0, done=0, busy=0, and clear all buffer words to 0.
REQ-032 Reset asserted mid-run SHALL abort the run with no done pulse; the first edge after release behaves as IDLE.

Verification
REQ-033 Load buf[0..2]=16'h0A53,16'hB011,16'h1112; prog_len=2; pulse start -> issue high 3 consecutive cycles with instruction 0A53,B011,1112 and pc 0,1,2; done pulses once on the next cycle.
REQ-034 Same program, pause=1 for 2 cycles while pc=1 -> sequence 0A53, B011, gap of 2 issue-low cycles, 1112; issue-high total = 3; busy high throughout.
REQ-035 prog_len=0, buf[0]=16'h0FF3 -> exactly one issue cycle with 0FF3, done pulse next cycle, back to IDLE.
REQ-036 While busy, write wr_addr=1 wr_data=16'hFFFF and assert start -> buf[1] unchanged on the next run and no restart occurs.
REQ-037 Assert rst asynchronously mid-run at pc=5 of prog_len=15 -> outputs zero immediately, no done pulse, and buf reads back all zeros on the next run.
REQ-038 prog_len=15 with all 16 words loaded -> 16 issue cycles with pc 0..15, no wrap to 0, done once.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: 16-entry program buffer that issues one stored
// instruction word per clock to an ALU datapath, with pause and done.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   wr_en/wr_addr/
//   wr_data           program-buffer write (accepted only when idle
//                     and not starting)
//   prog_len          index of the last instruction, sampled at start
//   start             run request (ignored unless idle)
//   pause             level-sensitive hold of issue
//   instruction       registered word presented to the datapath
//   issue             registered execute-enable for instruction
//   pc                registered program index
//   busy              high while running or paused
//   done              one-cycle completion pulse
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int IW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [3:0]    wr_addr,
    input  logic [IW-1:0] wr_data,
    input  logic [3:0]    prog_len,
    input  logic          start,
    input  logic          pause,
    output logic [IW-1:0] instruction,
    output logic          issue,
    output logic [3:0]    pc,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    last;
    logic [3:0]    pc_inc;
    logic          at_last;
    logic [IW-1:0] mem [DEPTH];

    assign pc_inc  = pc + 4'd1;
    assign at_last = (pc == last);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the final instruction wins over pause
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (at_last) begin
                    state_nxt = S_DONE;
                end else if (pause) begin
                    state_nxt = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (!pause) begin
                    state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = (state == S_RUN) || (state == S_PAUSED);
        done = (state == S_DONE);
    end

    // Issue datapath. Entering pause still advances pc because the
    // word on the bus during that cycle was already issued; resuming
    // re-fetches the word at the advanced pc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= 4'd0;
            last        <= 4'd0;
            instruction <= '0;
            issue       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        last        <= prog_len;
                        pc          <= 4'd0;
                        instruction <= mem[0];
                        issue       <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (at_last) begin
                        issue <= 1'b0;
                    end else if (pause) begin
                        issue <= 1'b0;
                        pc    <= pc_inc;
                    end else begin
                        pc          <= pc_inc;
                        instruction <= mem[pc_inc];
                        issue       <= 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        instruction <= mem[pc];
                        issue       <= 1'b1;
                    end
                end
                S_DONE: begin
                    issue <= 1'b0;
                end
            endcase
        end
    end

    // Program buffer: writable only while idle and not launching a run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == S_IDLE && wr_en && !start) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule
